// File: rtl/stopwatch_count_ctrl.sv
// stopwatch_count_ctrl: 4-digit BCD count datapath sequenced by the stopwatch mode FSM.
// Latency: state, count and flags update one clk after the inputs; count steps the cycle after tick.
// Backpressure: none; inputs are sampled every cycle, outputs are levels or one-cycle pulses.
// Optional feature macro: ALARM_BLINK_EN (blinking alarm while expired; default is a steady alarm).

module stopwatch_count_ctrl #(
  parameter int TICK_DIV  = 1000000,
  parameter int BLINK_DIV = 25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  current_state,
  input  logic [15:0] timeout,
  input  logic        clear_in,
  output logic [15:0] count_bcd,
  output logic        tick,
  output logic        running,
  output logic        ovf,
  output logic        expired,
  output logic        alarm
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  // Degenerate parameter values leave an empty marker block in the hierarchy.
  if (TICK_DIV < 2 || BLINK_DIV < 1) begin : g_bad_params
  end

  typedef enum logic [2:0] {
    ST_UP_HOLD,
    ST_UP_CNT,
    ST_DN_HOLD,
    ST_DN_CNT,
    ST_DN_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            lock_q, lock_d;      // cleared during down_run: idle at 0000 until mode leaves 11
  logic [PW-1:0]   presc_q, presc_d;
  logic [15:0]     count_q, count_d;
  logic [15:0]     timeout_q, timeout_d;
  logic            ovf_q, ovf_d;
  logic            expired_q;
  logic            alarm_q;
  logic [1:0]      grp_q;               // mode encoding the FSM currently represents
  logic            mode_chg, side_chg, cnt_state, tick_w;
  logic [16:0]     inc;

`ifdef ALARM_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
  logic [BW-1:0]   blink_q;
`endif

  // Digit-wise BCD increment; bit 16 is the carry out of the top digit.
  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  // Digit-wise BCD decrement; caller guarantees v is not 0000.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Non-decimal digits from the editor load as 9.
  function automatic logic [15:0] bcd_sat(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Decode which mode the FSM state stands for and whether the prescaler runs.
  always_comb begin
    grp_q = 2'b00;
    case (state_q)
      ST_UP_HOLD: grp_q = 2'b00;
      ST_UP_CNT:  grp_q = 2'b01;
      ST_DN_HOLD: grp_q = lock_q ? 2'b11 : 2'b10;
      default:    grp_q = 2'b11;
    endcase
    mode_chg  = (current_state != grp_q);
    side_chg  = (current_state[1] != grp_q[1]);
`ifdef ALARM_BLINK_EN
    cnt_state = (state_q == ST_UP_CNT) || (state_q == ST_DN_CNT) || (state_q == ST_DN_DONE);
`else
    cnt_state = (state_q == ST_UP_CNT) || (state_q == ST_DN_CNT);
`endif
    tick_w    = cnt_state && (presc_q == PRESC_MAX);
  end

  // Next FSM state: follows the mode, latches done and clear-idle while mode stays 11.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    case (current_state)
      2'b00: begin state_d = ST_UP_HOLD; lock_d = 1'b0; end
      2'b01: begin state_d = ST_UP_CNT;  lock_d = 1'b0; end
      2'b10: begin state_d = ST_DN_HOLD; lock_d = 1'b0; end
      default: begin
        if (clear_in || lock_q) begin
          state_d = ST_DN_HOLD;
          lock_d  = 1'b1;
        end else if (state_q == ST_DN_DONE) begin
          state_d = ST_DN_DONE;
        end else if (state_q == ST_DN_CNT &&
                     (count_q == 16'h0000 || (tick_w && count_q == 16'h0001))) begin
          state_d = ST_DN_DONE;
        end else begin
          state_d = ST_DN_CNT;
        end
      end
    endcase
  end

  // Next count/prescaler: clear beats mode change, which beats edit reload, which beats tick.
  always_comb begin
    count_d   = count_q;
    ovf_d     = 1'b0;
    timeout_d = timeout_q;
    inc       = bcd_inc(count_q);
    if (state_q == ST_DN_HOLD || (side_chg && current_state[1])) timeout_d = timeout;
    if (clear_in) begin
      count_d = 16'h0000;
    end else if (side_chg) begin
      count_d = current_state[1] ? bcd_sat(timeout) : 16'h0000;
    end else if (state_q == ST_DN_HOLD && !lock_q && timeout != timeout_q) begin
      count_d = bcd_sat(timeout);
    end else if (tick_w && !mode_chg) begin
      if (state_q == ST_UP_CNT) begin
        count_d = inc[15:0];
        ovf_d   = inc[16];
      end else if (state_q == ST_DN_CNT && count_q != 16'h0000) begin
        count_d = bcd_dec(count_q);
      end
    end
    if (clear_in || state_d != state_q || !cnt_state || tick_w) presc_d = '0;
    else presc_d = presc_q + PW'(1);
  end

  // All state, count and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_UP_HOLD;
      lock_q    <= 1'b0;
      presc_q   <= '0;
      count_q   <= 16'h0000;
      timeout_q <= 16'h0000;
      ovf_q     <= 1'b0;
      expired_q <= 1'b0;
      alarm_q   <= 1'b0;
`ifdef ALARM_BLINK_EN
      blink_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
      ovf_q     <= ovf_d;
      expired_q <= (state_d == ST_DN_DONE);
`ifdef ALARM_BLINK_EN
      if (state_d != ST_DN_DONE) begin
        alarm_q <= 1'b0;
        blink_q <= '0;
      end else if (state_q != ST_DN_DONE) begin
        alarm_q <= 1'b1;
        blink_q <= '0;
      end else if (tick_w) begin
        if (blink_q == BLINK_MAX) begin
          alarm_q <= ~alarm_q;
          blink_q <= '0;
        end else begin
          blink_q <= blink_q + BW'(1);
        end
      end
`else
      alarm_q   <= (state_d == ST_DN_DONE);
`endif
    end
  end

  assign count_bcd = count_q;
  assign tick      = tick_w;
  assign running   = (state_q == ST_UP_CNT) || (state_q == ST_DN_CNT);
  assign ovf       = ovf_q;
  assign expired   = expired_q;
  assign alarm     = alarm_q;

endmodule

// File: tb/tb_stopwatch_count_ctrl.sv
// Testbench for stopwatch_count_ctrl with TICK_DIV=4, BLINK_DIV=2.
// Expected counts are pushed to a queue when a tick is seen and popped after the count steps.
// Works for both the default build and ALARM_BLINK_EN.

module tb_stopwatch_count_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int BLINK_DIV = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  current_state;
  logic [15:0] timeout;
  logic        clear_in;
  logic [15:0] count_bcd;
  logic        tick;
  logic        running;
  logic        ovf;
  logic        expired;
  logic        alarm;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];

  stopwatch_count_ctrl #(.TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .current_state(current_state), .timeout(timeout),
    .clear_in(clear_in), .count_bcd(count_bcd), .tick(tick), .running(running),
    .ovf(ovf), .expired(expired), .alarm(alarm)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int k);
    return {4'(k / 1000 % 10), 4'(k / 100 % 10), 4'(k / 10 % 10), 4'(k % 10)};
  endfunction

  // Bounded wait (from a negedge) until tick is high at a negedge.
  task automatic wait_tick(output int cycles);
    cycles = 0;
    while (tick !== 1'b1 && cycles < 4 * TICK_DIV) begin
      @(negedge clk);
      cycles++;
    end
    if (tick !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_tick: tick=%b after %0d cycles, required 1", tick, cycles);
    end
  endtask

  task automatic test_reset();
    int cyc;
    logic [15:0] e;
    reset_n = 1'b0; current_state = 2'b00; timeout = 16'h0000; clear_in = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({count_bcd, tick, running, ovf, expired, alarm} !== 21'd0) begin
      n_err++; $display("FAIL reset_state: outputs=%h required 0", {count_bcd, tick, running, ovf, expired, alarm});
    end
    reset_n = 1'b1;
    @(negedge clk);
    current_state = 2'b01;
    for (int k = 1; k <= 42; k++) begin
      wait_tick(cyc);
      exp_q.push_back(to_bcd(k));
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (count_bcd !== e) begin n_err++; $display("FAIL t1_run: count=%h required %h", count_bcd, e); end
    end
    n_cmp++;
    if (running !== 1'b1) begin n_err++; $display("FAIL t1_running: running=%b required 1", running); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({count_bcd, tick, running, ovf, expired, alarm} !== 21'd0) begin
      n_err++; $display("FAIL t1_async_reset: outputs=%h required 0", {count_bcd, tick, running, ovf, expired, alarm});
    end
    current_state = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({count_bcd, running} !== 17'd0) begin
        n_err++; $display("FAIL t1_hold_after_reset: count=%h running=%b required 0000/0", count_bcd, running);
      end
    end
  endtask

  task automatic test_up_wrap();
    int cyc;
    logic [15:0] e;
    logic eo;
    current_state = 2'b01;
    for (int k = 1; k <= 10000; k++) begin
      wait_tick(cyc);
      exp_q.push_back(to_bcd(k % 10000));
      @(negedge clk);
      e  = exp_q.pop_front();
      eo = (k == 10000);
      n_cmp++;
      if (count_bcd !== e) begin n_err++; $display("FAIL t2_up_count: count=%h required %h", count_bcd, e); end
      n_cmp++;
      if (ovf !== eo) begin n_err++; $display("FAIL t2_ovf: ovf=%b required %b at step %0d", ovf, eo, k); end
    end
    @(negedge clk);
    n_cmp++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL t2_ovf_single: ovf=%b required 0", ovf); end
    current_state = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_countdown();
    int cyc;
    logic [15:0] e;
    timeout = 16'h0003; current_state = 2'b10;
    @(negedge clk);
    n_cmp++;
    if (count_bcd !== 16'h0003) begin n_err++; $display("FAIL t3_load: count=%h required 0003", count_bcd); end
    current_state = 2'b11;
    for (int j = 1; j <= 3; j++) begin
      wait_tick(cyc);
      n_cmp++;
      if (cyc !== ((j == 1) ? 4 : 3)) begin
        n_err++; $display("FAIL t3_spacing: waited %0d cycles required %0d", cyc, (j == 1) ? 4 : 3);
      end
      exp_q.push_back(to_bcd(3 - j));
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (count_bcd !== e) begin n_err++; $display("FAIL t3_count: count=%h required %h", count_bcd, e); end
    end
    n_cmp++;
    if ({expired, running} !== 2'b10) begin
      n_err++; $display("FAIL t3_expired: expired=%b running=%b required 1/0", expired, running);
    end
    repeat (20) begin
      @(negedge clk);
      n_cmp++;
      if ({count_bcd, expired} !== {16'h0000, 1'b1}) begin
        n_err++; $display("FAIL t3_stay_zero: count=%h expired=%b required 0000/1", count_bcd, expired);
      end
    end
  endtask

  task automatic test_alarm();
    int cyc;
    logic [15:0] e;
    current_state = 2'b10; timeout = 16'h0001;
    @(negedge clk);
    n_cmp++;
    if ({expired, alarm} !== 2'b00) begin n_err++; $display("FAIL t6_leave_done: expired/alarm=%b%b required 00", expired, alarm); end
    @(negedge clk);
    n_cmp++;
    if (count_bcd !== 16'h0001) begin n_err++; $display("FAIL t6_reload: count=%h required 0001", count_bcd); end
    current_state = 2'b11;
    wait_tick(cyc);
    exp_q.push_back(16'h0000);
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (count_bcd !== e) begin n_err++; $display("FAIL t6_count: count=%h required %h", count_bcd, e); end
    n_cmp++;
    if ({expired, alarm} !== 2'b11) begin n_err++; $display("FAIL t6_entry: expired/alarm=%b%b required 11", expired, alarm); end
`ifdef ALARM_BLINK_EN
    for (int t = 0; t < 4; t++) begin
      wait_tick(cyc);
      n_cmp++;
      if (alarm !== (t < 2)) begin n_err++; $display("FAIL t6_blink: alarm=%b required %b at tick %0d", alarm, (t < 2), t); end
      n_cmp++;
      if (running !== 1'b0) begin n_err++; $display("FAIL t6_running: running=%b required 0", running); end
      @(negedge clk);
    end
`else
    repeat (8) begin
      @(negedge clk);
      n_cmp++;
      if ({alarm, expired, tick} !== 3'b110) begin
        n_err++; $display("FAIL t6_steady: alarm/expired/tick=%b%b%b required 110", alarm, expired, tick);
      end
    end
`endif
    current_state = 2'b10;
    @(negedge clk);
    n_cmp++;
    if ({expired, alarm} !== 2'b00) begin n_err++; $display("FAIL t6_exit: expired/alarm=%b%b required 00", expired, alarm); end
  endtask

  task automatic test_pause_edit();
    int cyc;
    logic [15:0] e;
    timeout = 16'h0100;
    @(negedge clk);
    n_cmp++;
    if (count_bcd !== 16'h0100) begin n_err++; $display("FAIL t4_edit_load: count=%h required 0100", count_bcd); end
    current_state = 2'b11;
    for (int j = 1; j <= 3; j++) begin
      wait_tick(cyc);
      exp_q.push_back(to_bcd(100 - j));
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (count_bcd !== e) begin n_err++; $display("FAIL t4_down: count=%h required %h", count_bcd, e); end
    end
    current_state = 2'b10;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (count_bcd !== 16'h0097) begin n_err++; $display("FAIL t4_paused: count=%h required 0097", count_bcd); end
    end
    current_state = 2'b11;
    wait_tick(cyc);
    n_cmp++;
    if (cyc !== 4) begin n_err++; $display("FAIL t4_resume_spacing: waited %0d cycles required 4", cyc); end
    exp_q.push_back(16'h0096);
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (count_bcd !== e) begin n_err++; $display("FAIL t4_resume: count=%h required %h", count_bcd, e); end
    current_state = 2'b10; timeout = 16'h0200;
    @(negedge clk);
    n_cmp++;
    if (count_bcd !== 16'h0096) begin n_err++; $display("FAIL t4_pause_keep: count=%h required 0096", count_bcd); end
    @(negedge clk);
    n_cmp++;
    if (count_bcd !== 16'h0200) begin n_err++; $display("FAIL t4_edit: count=%h required 0200", count_bcd); end
  endtask

  task automatic test_simultaneous();
    int cyc;
    logic [15:0] e;
    current_state = 2'b01;
    @(negedge clk);
    n_cmp++;
    if (count_bcd !== 16'h0000) begin n_err++; $display("FAIL t5_up_entry: count=%h required 0000", count_bcd); end
    wait_tick(cyc);
    exp_q.push_back(16'h0001);
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (count_bcd !== e) begin n_err++; $display("FAIL t5_up: count=%h required %h", count_bcd, e); end
    wait_tick(cyc);
    clear_in = 1'b1;
    @(negedge clk);
    clear_in = 1'b0;
    n_cmp++;
    if (count_bcd !== 16'h0000) begin n_err++; $display("FAIL t5_clear_beats_tick: count=%h required 0000", count_bcd); end
    wait_tick(cyc);
    exp_q.push_back(16'h0001);
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (count_bcd !== e) begin n_err++; $display("FAIL t5_after_clear: count=%h required %h", count_bcd, e); end
    wait_tick(cyc);
    current_state = 2'b00;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if ({count_bcd, running} !== {16'h0001, 1'b0}) begin
        n_err++; $display("FAIL t5_chg_drops_tick: count=%h running=%b required 0001/0", count_bcd, running);
      end
    end
    timeout = 16'h00A5; current_state = 2'b10;
    @(negedge clk);
    n_cmp++;
    if (count_bcd !== 16'h0095) begin n_err++; $display("FAIL t5_sat_load: count=%h required 0095", count_bcd); end
  endtask

  task automatic test_clear_down();
    int cyc;
    logic [15:0] e;
    current_state = 2'b11;
    wait_tick(cyc);
    exp_q.push_back(to_bcd(94));
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (count_bcd !== e) begin n_err++; $display("FAIL t5_down: count=%h required %h", count_bcd, e); end
    clear_in = 1'b1;
    @(negedge clk);
    clear_in = 1'b0;
    n_cmp++;
    if ({count_bcd, running, expired, alarm} !== 19'd0) begin
      n_err++; $display("FAIL t5_clear_dn: count=%h run/exp/alarm=%b%b%b required 0000/000", count_bcd, running, expired, alarm);
    end
    repeat (12) begin
      @(negedge clk);
      n_cmp++;
      if ({count_bcd, tick, running, expired, alarm} !== 20'd0) begin
        n_err++; $display("FAIL t5_clear_idle: count=%h tick/run/exp/alarm=%b%b%b%b required all 0", count_bcd, tick, running, expired, alarm);
      end
    end
    current_state = 2'b10;
    @(negedge clk);
    n_cmp++;
    if (count_bcd !== 16'h0000) begin n_err++; $display("FAIL t5_release: count=%h required 0000", count_bcd); end
    current_state = 2'b11;
    @(negedge clk);
    n_cmp++;
    if ({running, expired} !== 2'b10) begin n_err++; $display("FAIL t5_zero_entry: run/exp=%b%b required 10", running, expired); end
    @(negedge clk);
    n_cmp++;
    if ({count_bcd, running, expired} !== {16'h0000, 2'b01}) begin
      n_err++; $display("FAIL t5_zero_done: count=%h run/exp=%b%b required 0000/01", count_bcd, running, expired);
    end
    current_state = 2'b10;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_countdown();
    test_alarm();
    test_pause_edit();
    test_simultaneous();
    test_clear_down();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
